// File: rtl/uart_pkg.sv
// Shared line levels, stream header and controller state encoding for the
// accumulator result streamer.
package uart_pkg;

   localparam logic       UART_IDLE     = 1'b1;
   localparam logic       UART_START    = 1'b0;
   localparam logic       UART_STOP     = 1'b1;
   localparam logic [7:0] STREAM_HEADER = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      SEND_HDR,
      FETCH,
      CAPTURE,
      SEND_BYTE,
      TX_WAIT,
      FINISH
   } streamer_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: one start bit, eight data bits LSB first, one stop bit,
// each held CLK_PER_BIT cycles; tx_done pulses after the stop bit completes.
module uart_tx_byte
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       uart_tx
);

   localparam int BAUD_W = $clog2(CLK_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);

   logic [BAUD_W-1:0] r_baud_cnt;
   logic [3:0]        r_bit_cnt;
   logic [7:0]        r_shift;
   logic              r_active;
   logic              r_done;
   logic              r_tx;

   // r_bit_cnt: 0 = start bit, 1..8 = data bits, 9 = stop bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_active   <= 1'b0;
         r_done     <= 1'b0;
         r_tx       <= UART_IDLE;
      end else begin
         r_done <= 1'b0;
         if (!r_active) begin
            if (tx_start) begin
               r_active   <= 1'b1;
               r_shift    <= tx_data;
               r_bit_cnt  <= '0;
               r_baud_cnt <= '0;
               r_tx       <= UART_START;
            end
         end else if (r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == 4'd9) begin
               r_active <= 1'b0;
               r_done   <= 1'b1;
               r_tx     <= UART_IDLE;
            end else begin
               r_bit_cnt <= r_bit_cnt + 4'd1;
               if (r_bit_cnt == 4'd8) begin
                  r_tx <= UART_STOP;
               end else begin
                  r_tx    <= r_shift[0];
                  r_shift <= {1'b0, r_shift[7:1]};
               end
            end
         end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
         end
      end
   end

   assign tx_busy = r_active;
   assign tx_done = r_done;
   assign uart_tx = r_tx;

endmodule

// File: rtl/uart_result_streamer.sv
// Streams a run of accumulator words to the host: header byte A5, then each
// word little-endian as 8N1 frames. One read per word, addresses wrap.
module uart_result_streamer
   import uart_pkg::*;
#(
   parameter int ACC_WIDTH      = 32,
   parameter int MATRIX_SIZE    = 8,
   parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE*MATRIX_SIZE),
   parameter int F_CLK          = 50_000_000,
   parameter int BAUD           = 921_600,
   parameter int CLK_PER_BIT    = F_CLK/BAUD
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [ACC_ADDR_WIDTH-1:0] base_addr,
   input  logic [ACC_ADDR_WIDTH:0]   count,
   output logic [ACC_ADDR_WIDTH-1:0] acc_rd_addr,
   input  logic [ACC_WIDTH-1:0]      acc_rd_data,
   output logic                      busy,
   output logic                      done,
   output logic                      uart_tx
);

   localparam int BYTES_PER_WORD = ACC_WIDTH/8;
   localparam int MAX_WORDS      = MATRIX_SIZE*MATRIX_SIZE;
   localparam int BIDX_W         = $clog2(BYTES_PER_WORD + 1);
   localparam logic [ACC_ADDR_WIDTH:0] MAX_COUNT = (ACC_ADDR_WIDTH+1)'(MAX_WORDS);
   localparam logic [BIDX_W-1:0]       LAST_IDX  = BIDX_W'(BYTES_PER_WORD);

   streamer_state_t           r_state;
   logic [ACC_ADDR_WIDTH-1:0] r_addr;
   logic [ACC_ADDR_WIDTH:0]   r_words_left;
   logic [BIDX_W-1:0]         r_byte_idx;
   logic [ACC_WIDTH-1:0]      r_word;
   logic                      r_hdr_phase;

   logic [ACC_ADDR_WIDTH:0]   w_count;
   logic                      w_tx_start;
   logic [7:0]                w_tx_data;
   logic                      w_tx_busy;
   logic                      w_tx_done;

   assign w_count    = (count > MAX_COUNT) ? MAX_COUNT : count;
   assign w_tx_start = ((r_state == SEND_HDR) || (r_state == SEND_BYTE)) && !w_tx_busy;
   assign w_tx_data  = (r_state == SEND_HDR) ? STREAM_HEADER : r_word[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_words_left <= '0;
         r_byte_idx   <= '0;
         r_word       <= '0;
         r_hdr_phase  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_addr       <= base_addr;
                  r_words_left <= w_count;
                  r_hdr_phase  <= 1'b1;
                  r_state      <= (count == '0) ? FINISH : SEND_HDR;
               end
            end
            SEND_HDR: begin
               if (!w_tx_busy) r_state <= TX_WAIT;
            end
            FETCH: r_state <= CAPTURE;
            CAPTURE: begin
               r_word       <= acc_rd_data;
               r_byte_idx   <= '0;
               r_words_left <= r_words_left - 1'b1;
               r_addr       <= r_addr + 1'b1;
               r_state      <= SEND_BYTE;
            end
            // The low byte goes out now; shift so the next one is ready.
            SEND_BYTE: begin
               if (!w_tx_busy) begin
                  r_word     <= r_word >> 8;
                  r_byte_idx <= r_byte_idx + 1'b1;
                  r_state    <= TX_WAIT;
               end
            end
            TX_WAIT: begin
               if (w_tx_done) begin
                  if (r_hdr_phase) begin
                     r_hdr_phase <= 1'b0;
                     r_state     <= FETCH;
                  end else if (r_byte_idx != LAST_IDX) begin
                     r_state <= SEND_BYTE;
                  end else if (r_words_left != '0) begin
                     r_state <= FETCH;
                  end else begin
                     r_state <= FINISH;
                  end
               end
            end
            FINISH:  r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign acc_rd_addr = r_addr;
   assign busy        = (r_state != IDLE) && (r_state != FINISH);
   assign done        = (r_state == FINISH);

   uart_tx_byte #(
      .CLK_PER_BIT(CLK_PER_BIT)
   ) u_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_start(w_tx_start),
      .tx_data (w_tx_data),
      .tx_busy (w_tx_busy),
      .tx_done (w_tx_done),
      .uart_tx (uart_tx)
   );

endmodule

// File: tb/tb_uart_result_streamer.sv
// Bench for uart_result_streamer: decodes the serial line into bytes and checks
// them, frame timing and the busy/done handshake against a byte-queue model.
module tb_uart_result_streamer;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  base_addr = '0;
   logic [6:0]  count = '0;
   logic [5:0]  acc_rd_addr;
   logic [31:0] acc_rd_data;
   logic        busy;
   logic        done;
   logic        uart_tx;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [64];
   logic [7:0]  exp_q [$];
   logic [7:0]  rx_log [$];

   int  ncyc = 0;
   int  s_cyc = 0;
   int  last_end = 0;
   int  done_cnt = 0;
   int  d_base = 0;
   int  model_n = 0;
   int  dec_n = 0;
   bit  have_end = 0;
   bit  first_pending = 0;
   bit  pend_chk = 0;
   bit  prev_done = 0;
   bit  tb_start_accept = 0;
   logic [39:0] dec_s;

   uart_result_streamer #(
      .ACC_WIDTH  (32),
      .MATRIX_SIZE(8),
      .CLK_PER_BIT(CPB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .count      (count),
      .acc_rd_addr(acc_rd_addr),
      .acc_rd_data(acc_rd_data),
      .busy       (busy),
      .done       (done),
      .uart_tx    (uart_tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) acc_rd_data <= mem[acc_rd_addr];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic decode_frame();
      bit          ok;
      logic [7:0]  b;
      ok = 1'b1;
      for (int i = 0; i < 10; i++)
         for (int k = 1; k < 4; k++)
            if (dec_s[4*i+k] !== dec_s[4*i]) ok = 1'b0;
      chk("bit_width", int'(ok), 1);
      chk("start_bit", int'(dec_s[0]), 0);
      chk("stop_bit", int'(dec_s[36]), 1);
      for (int j = 0; j < 8; j++) b[j] = dec_s[4*(j+1)];
      rx_log.push_back(b);
      if (exp_q.size() == 0) begin
         chk("unexpected_byte", int'(b), -1);
      end else begin
         chk("rx_byte", int'(b), int'(exp_q.pop_front()));
      end
      $display("[TB] byte %0d rx=%02h", rx_log.size() - 1, b);
   endtask

   // Per-cycle checks and the line decoder, sampled away from the active edge.
   always @(negedge clk) begin
      ncyc++;
      if (!busy) chk("line_idle", int'(uart_tx), 1);
      if (!rst_n) begin
         dec_n = 0;
         have_end = 0;
         first_pending = 0;
         pend_chk = 0;
         prev_done = 0;
      end else begin
         if (pend_chk) begin
            pend_chk = 0;
            if (model_n == 0) begin
               chk("done_after_start", int'(done), 1);
               chk("busy_zero_count", int'(busy), 0);
            end else begin
               chk("busy_after_start", int'(busy), 1);
               chk("no_early_done", int'(done), 0);
            end
         end
         if (start && tb_start_accept) begin
            pend_chk = 1;
            s_cyc = ncyc;
            first_pending = (model_n != 0);
         end
         if (done) begin
            chk("busy_low_at_done", int'(busy), 0);
            chk("done_single", int'(prev_done), 0);
            chk("bytes_left_at_done", exp_q.size(), 0);
            done_cnt++;
            have_end = 0;
         end
         prev_done = done;
         if (dec_n == 0) begin
            if (uart_tx == 1'b0) begin
               if (first_pending) begin
                  chk("first_start_latency", int'(ncyc - s_cyc <= 4), 1);
                  first_pending = 0;
               end else if (have_end) begin
                  chk("frame_gap", int'(ncyc - last_end - 1 <= 4), 1);
               end
               dec_s[0] = 1'b0;
               dec_n = 1;
            end
         end else begin
            dec_s[dec_n] = uart_tx;
            dec_n++;
            if (dec_n == 40) begin
               dec_n = 0;
               last_end = ncyc;
               have_end = 1;
               decode_frame();
            end
         end
      end
   end

   task automatic do_xfer(input int base, input int cnt);
      logic [31:0] w;
      model_n = (cnt > 64) ? 64 : cnt;
      exp_q.delete();
      rx_log.delete();
      if (model_n != 0) exp_q.push_back(8'hA5);
      for (int i = 0; i < model_n; i++) begin
         w = mem[(base + i) % 64];
         for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
      end
      d_base = done_cnt;
      @(posedge clk);
      #1;
      base_addr = 6'(base);
      count = 7'(cnt);
      start = 1'b1;
      tb_start_accept = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      tb_start_accept = 1'b0;
   endtask

   task automatic wait_done(input int limit, input string name);
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done_cnt > d_base) break;
      end
      repeat (5) @(negedge clk);
      chk({name, "_done_count"}, done_cnt - d_base, 1);
      chk({name, "_busy_after"}, int'(busy), 0);
      $display("[TB] transfer %s: %0d bytes received", name, rx_log.size());
   endtask

   logic [7:0] lit_one  [5]  = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12};
   logic [7:0] lit_wrap [17] = '{8'hA5, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h3F, 8'h00, 8'h00,
                                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};

   initial begin
      int dcnt;
      bit seen;
      for (int i = 0; i < 64; i++) mem[i] = 32'(i);

      // Reset values and a quiet line with no request
      repeat (3) @(negedge clk);
      chk("rst_uart_tx", int'(uart_tx), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_addr", int'(acc_rd_addr), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (1000) @(negedge clk);
      chk("idle_no_frames", rx_log.size(), 0);
      chk("idle_no_done", done_cnt, 0);

      // Single word
      mem[0] = 32'h12345678;
      do_xfer(0, 1);
      wait_done(2000, "single");
      chk("single_len", rx_log.size(), 5);
      for (int i = 0; i < 5 && i < rx_log.size(); i++)
         chk("single_lit", int'(rx_log[i]), int'(lit_one[i]));
      mem[0] = 32'h0;

      // count = 0
      do_xfer(3, 0);
      wait_done(50, "zero");
      chk("zero_no_bytes", rx_log.size(), 0);

      // Address wrap
      do_xfer(62, 4);
      wait_done(4000, "wrap");
      chk("wrap_len", rx_log.size(), 17);
      for (int i = 0; i < 17 && i < rx_log.size(); i++)
         chk("wrap_lit", int'(rx_log[i]), int'(lit_wrap[i]));

      // Clamp to 64 words, with an ignored start mid-transfer
      do_xfer(10, 100);
      repeat (500) @(posedge clk);
      #1;
      base_addr = 6'd0;
      count = 7'd1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(20000, "clamp");
      chk("clamp_len", rx_log.size(), 257);

      // Reset during the third data bit of the first data byte (08: bit2 = 0)
      do_xfer(8, 2);
      for (int i = 0; i < 200 && rx_log.size() < 1; i++) @(negedge clk);
      chk("hdr_before_reset", rx_log.size(), 1);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (uart_tx == 1'b0) seen = 1;
      end
      chk("data_frame_started", int'(seen), 1);
      repeat (12) @(negedge clk);
      chk("pre_reset_bit2", int'(uart_tx), 0);
      #1 rst_n = 1'b0;
      #1;
      chk("reset_tx_async", int'(uart_tx), 1);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      exp_q.delete();
      dcnt = done_cnt;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("no_done_on_reset", done_cnt - dcnt, 0);

      // Fresh transfer after reset
      do_xfer(1, 2);
      wait_done(4000, "after_reset");
      chk("after_reset_len", rx_log.size(), 9);
      if (rx_log.size() > 1) begin
         chk("after_reset_hdr", int'(rx_log[0]), 8'hA5);
         chk("after_reset_b1", int'(rx_log[1]), 8'h01);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_result_streamer.md
Name: uart_result_streamer

Overview:
- Return path of the host UART link. It reads a run of 32-bit accumulator results from the systolic array's accumulator read port and serializes them to the host as 8N1 UART bytes.
- It is the transmit counterpart of the UART instruction loader: the loader brings programs in, this block carries results out.
- The control FSM starts it with a single pulse and gets a done pulse back.

Parameters:
- ACC_WIDTH, 32, accumulator word width; must be a multiple of 8.
- MATRIX_SIZE, 8, systolic array dimension.
- ACC_ADDR_WIDTH, $clog2(MATRIX_SIZE*MATRIX_SIZE), accumulator address width.
- F_CLK, 50_000_000, clock frequency in Hz.
- BAUD, 921_600, line rate.
- CLK_PER_BIT, F_CLK/BAUD, clock cycles per UART bit; must be >= 4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to stream.
- base_addr  in  ACC_ADDR_WIDTH  first accumulator address; sampled on start.
- count  in  ACC_ADDR_WIDTH+1  number of words to send; sampled on start.
- acc_rd_addr  out  ACC_ADDR_WIDTH  accumulator read address.
- acc_rd_data  in  ACC_WIDTH  accumulator data; valid 1 cycle after acc_rd_addr.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the transfer completes.
- uart_tx  out  1  serial line; idle level is high.

Behaviour:
- Clocking and reset: one clock domain (clk), asynchronous active-low reset (rst_n).
- Reset values: uart_tx=1, busy=0, done=0, acc_rd_addr=0. All counters and registers clear.
- Reset asserted mid-frame: uart_tx goes high immediately (asynchronous), the partial frame is abandoned, and done is not pulsed.
- start acceptance: start is accepted only in IDLE. A start while busy is ignored, including in the done cycle.
- count handling:
  - count=0: no line activity; done pulses the cycle after start; busy stays 0.
  - count > MATRIX_SIZE^2: clamped to MATRIX_SIZE^2.
- Addressing: word i is read from (base_addr+i) mod 2^ACC_ADDR_WIDTH, so addresses wrap.
- Stream format:
  - One header byte 8'hA5.
  - Then each word, little-endian: byte 0 = bits [7:0] first, ACC_WIDTH/8 bytes per word.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit holds for exactly CLK_PER_BIT cycles.
- Inter-frame spacing:
  - Idle-high gap between frames within one transfer is at most 4 cycles.
  - The first start bit begins at most 4 cycles after start.
- FSM states:
  - IDLE: on start with count!=0, go to SEND_HDR.
  - SEND_HDR: load A5 into the byte transmitter; go to TX_WAIT.
  - FETCH: drive acc_rd_addr; go to CAPTURE.
  - CAPTURE: latch acc_rd_data into the word shift register; byte index = 0; go to SEND_BYTE.
  - SEND_BYTE: start the byte transmitter; go to TX_WAIT.
  - TX_WAIT: on byte-done, go to one of:
    - SEND_BYTE, if bytes remain in the current word;
    - FETCH, if words remain;
    - FINISH, otherwise.
    - After the header frame, go to FETCH.
  - FINISH: done=1 for one cycle, busy=0, go to IDLE.
- Word read: exactly one acc_rd_addr read per word. acc_rd_data is ignored outside CAPTURE.
- busy falls in the same cycle that done rises.
- The transfer ends after the stop bit of the final byte has been held for its full CLK_PER_BIT cycles.
- Total line time for N words: (1 + N*ACC_WIDTH/8) * 10 * CLK_PER_BIT cycles, plus gaps.

Decomposition:
- Package uart_pkg holds:
  - UART_IDLE=1'b1, UART_START=1'b0, UART_STOP=1'b1;
  - STREAM_HEADER=8'hA5;
  - streamer_state_t enum: IDLE, SEND_HDR, FETCH, CAPTURE, SEND_BYTE, TX_WAIT, FINISH.
- One sub-module, uart_tx_byte: inputs tx_start and tx_data[7:0]; outputs tx_busy, tx_done (pulse), uart_tx.
  - Internally a bit counter 0..9 and a baud counter 0..CLK_PER_BIT-1.
- The streamer owns the sequencing and the word/byte counters.

Test Plan:
- Reset: hold rst_n=0, then release → uart_tx=1, busy=0, done=0; the line stays high for 1000 cycles with no start.
- Single word, CLK_PER_BIT=4: base=0, count=1, memory[0]=32'h12345678 → decoded bytes A5,78,56,34,12; each bit is 4 cycles wide; exactly one done pulse; busy=0 afterwards.
- count=0 → done pulses the cycle after start; busy never rises; uart_tx stays 1.
- Wrap, memory[i]=i: base=62, count=4 → acc_rd_addr sequence 62,63,0,1; bytes A5, 3E,00,00,00, 3F,00,00,00, 00,00,00,00, 01,00,00,00.
- Second start pulse mid-transfer → ignored; byte count is unchanged and only one done is produced. count=100 is clamped: 64 words (256 data bytes) are sent.
- Reset asserted during the 3rd data bit → uart_tx=1 in the same cycle, busy=0. A fresh start after release streams correctly from its header.
